sort_job_ctrl: RTL and testbench

SORT_JOB_CTRL -- requirements
Module: sort_job_ctrl

---
 rtl/sort_pkg.sv | 33 +++
 rtl/sort_cmd_if.sv | 57 +++++
 rtl/sort_job_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sort_job_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sort job controller and its
// sorter command interface.
package sort_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'b0000,
      CLR    = 4'b0001,
      CLR_W  = 4'b0011,
      LOAD   = 4'b0010,
      PUSH_W = 4'b0110,
      SORT_W = 4'b0111,
      POP    = 4'b0101,
      POP_W  = 4'b0100,
      OUT    = 4'b1100,
      FIN    = 4'b1101
   } state_e;

   typedef enum logic [1:0] {
      CMD_POP   = 2'd0,
      CMD_SORT  = 2'd1,
      CMD_PUSH  = 2'd2,
      CMD_CLR   = 2'd3
   } cmd_e;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_LEN   = 2'd1;
   localparam logic [1:0] ERR_TMO   = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   localparam int MAX_LEN_DEF = 255;
   localparam int WCNT_W      = 18;

endpackage

// File: rtl/sort_cmd_if.sv
// Toggle-encoded sorter command lines plus the wait-state cycle counter
// that produces the completion and timeout strobes.
module sort_cmd_if
   import sort_pkg::*;
#(
   parameter int TIMEOUT = 200000
) (
   input  logic clk,
   input  logic rstn,
   input  logic cmd_en_i,
   input  cmd_e cmd_i,
   input  logic wait_i,
   input  logic s_idle_i,
   output logic s_clear_o,
   output logic s_push_o,
   output logic s_sort_o,
   output logic s_pop_o,
   output logic ack_o,
   output logic tmo_o
);

   localparam logic [WCNT_W-1:0] TmoLast = WCNT_W'(TIMEOUT - 1);

   logic [3:0]        lvl_q, lvl_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   always_comb begin
      lvl_d  = lvl_q;
      wcnt_d = wcnt_q;
      if (cmd_en_i) begin
         lvl_d  = lvl_q ^ (4'b0001 << cmd_i);
         wcnt_d = '0;
      end else if (wait_i) begin
         wcnt_d = wcnt_q + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lvl_q  <= '0;
         wcnt_q <= '0;
      end else begin
         lvl_q  <= lvl_d;
         wcnt_q <= wcnt_d;
      end
   end

   // s_idle is stale on the first wait edge, so a zero count blocks ack
   assign ack_o = wait_i && (wcnt_q != '0) && s_idle_i;
   assign tmo_o = wait_i && (wcnt_q == TmoLast);

   assign s_pop_o   = lvl_q[CMD_POP];
   assign s_sort_o  = lvl_q[CMD_SORT];
   assign s_push_o  = lvl_q[CMD_PUSH];
   assign s_clear_o = lvl_q[CMD_CLR];

endmodule

// File: rtl/sort_job_ctrl.sv
// Sort job controller: clears and loads an external sorter, sorts,
// then streams the words back out with timeout and abort handling.
module sort_job_ctrl
   import sort_pkg::*;
#(
   parameter int TIMEOUT = 200000,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic        abort,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        s_clear,
   output logic        s_push,
   output logic        s_pop,
   output logic        s_sort,
   output logic [15:0] s_din,
   input  logic [15:0] s_dout,
   input  logic        s_idle
);

   localparam int unsigned MaxLen = MAX_LEN;

   state_e      state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  ld_cnt_q, ld_cnt_d;
   logic [7:0]  pop_cnt_q, pop_cnt_d;
   logic        abt_q, abt_d;
   logic [15:0] s_din_q, s_din_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_valid_q, out_valid_d;
   logic        out_last_q, out_last_d;
   logic        in_ready_q, in_ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;

   logic cmd_en, ack, tmo, wait_st, abt, len_ok;
   logic len_bad, abt_take, push_take, out_take;
   cmd_e cmd;

   assign wait_st = (state_q == CLR_W) || (state_q == PUSH_W)
                 || (state_q == SORT_W) || (state_q == POP_W);
   assign abt     = abt_q | abort;
   assign len_ok  = (len != 8'd0) && (32'(len) <= MaxLen);
   assign len_bad = (state_q == IDLE) && start && !len_ok;

   // Abort never cuts a wait short; timeout outranks it
   assign abt_take = abt && !tmo
                  && ((state_q == LOAD) || (state_q == OUT)
                      || (wait_st && ack));
   assign push_take = (state_q == LOAD) && in_valid && in_ready_q && !abt;
   assign out_take  = (state_q == OUT) && out_valid_q && out_ready && !abt;

   sort_cmd_if #(
      .TIMEOUT (TIMEOUT)
   ) u_cmd (
      .clk       (clk),
      .rstn      (rstn),
      .cmd_en_i  (cmd_en),
      .cmd_i     (cmd),
      .wait_i    (wait_st),
      .s_idle_i  (s_idle),
      .s_clear_o (s_clear),
      .s_push_o  (s_push),
      .s_sort_o  (s_sort),
      .s_pop_o   (s_pop),
      .ack_o     (ack),
      .tmo_o     (tmo)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tmo || abt_take) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start && len_ok) state_d = CLR;
            CLR:     state_d = CLR_W;
            CLR_W:   if (ack) state_d = LOAD;
            LOAD:    if (push_take) state_d = PUSH_W;
            PUSH_W:  if (ack) state_d = (ld_cnt_q == len_q) ? SORT_W : LOAD;
            SORT_W:  if (ack) state_d = POP;
            POP:     state_d = POP_W;
            POP_W:   if (ack) state_d = OUT;
            OUT:     if (out_take) state_d = out_last_q ? FIN : POP;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cmd_en     = 1'b0;
      cmd        = CMD_CLR;
      len_d      = len_q;
      ld_cnt_d   = ld_cnt_q;
      pop_cnt_d  = pop_cnt_q;
      s_din_d    = s_din_q;
      out_data_d = out_data_q;
      unique case (1'b1)
         (state_q == IDLE) && (state_d == CLR): begin
            len_d     = len;
            ld_cnt_d  = '0;
            pop_cnt_d = '0;
         end
         state_q == CLR: begin
            cmd_en = 1'b1;
            cmd    = CMD_CLR;
         end
         push_take: begin
            cmd_en   = 1'b1;
            cmd      = CMD_PUSH;
            s_din_d  = in_data;
            ld_cnt_d = ld_cnt_q + 8'd1;
         end
         (state_q == PUSH_W) && (state_d == SORT_W): begin
            cmd_en = 1'b1;
            cmd    = CMD_SORT;
         end
         state_q == POP: begin
            cmd_en    = 1'b1;
            cmd       = CMD_POP;
            pop_cnt_d = pop_cnt_q + 8'd1;
         end
         (state_q == POP_W) && (state_d == OUT): out_data_d = s_dout;
         default: ;
      endcase
      abt_d       = abt && (state_q != IDLE) && (state_d != IDLE);
      in_ready_d  = state_d == LOAD;
      out_valid_d = state_d == OUT;
      out_last_d  = (state_d == OUT) && (pop_cnt_q == len_q);
      busy_d      = (state_d != IDLE) && (state_d != FIN);
      done_d      = state_d == FIN;
      err_d       = len_bad || tmo || abt_take;
      err_code_d  = tmo      ? ERR_TMO   :
                    abt_take ? ERR_ABORT :
                    len_bad  ? ERR_LEN   : ERR_NONE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_q       <= '0;
         ld_cnt_q    <= '0;
         pop_cnt_q   <= '0;
         abt_q       <= 1'b0;
         s_din_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         len_q       <= len_d;
         ld_cnt_q    <= ld_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         abt_q       <= abt_d;
         s_din_q     <= s_din_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;
   assign s_din     = s_din_q;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Directed bench for sort_job_ctrl with a behavioural descending sorter
// whose idle line can be held low to force timeouts.
module tb_sort_job_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start, abort, in_valid, out_ready;
   logic [7:0]  len;
   logic [15:0] in_data;
   logic        in_ready, out_valid, out_last;
   logic [15:0] out_data;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic        s_clear, s_push, s_pop, s_sort;
   logic [15:0] s_din;
   logic [15:0] s_dout = 16'h0;
   logic        s_idle;

   int ntot = 0, npass = 0, nfail = 0;

   always #5 clk = ~clk;

   sort_job_ctrl #(.TIMEOUT(50), .MAX_LEN(200)) dut (
      .clk(clk), .rstn(rstn), .start(start), .len(len), .abort(abort),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .s_clear(s_clear), .s_push(s_push),
      .s_pop(s_pop), .s_sort(s_sort), .s_din(s_din), .s_dout(s_dout),
      .s_idle(s_idle)
   );

   // Sorter model: each command makes it busy for a few cycles
   logic [15:0] sq[$];
   logic [3:0]  pv = 4'h0;
   int          bcnt = 0;
   logic        hang = 1'b0;

   assign s_idle = !hang && (bcnt == 0);

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pv   <= 4'h0;
         bcnt <= 0;
         sq.delete();
      end else begin
         pv <= {s_clear, s_push, s_sort, s_pop};
         if (bcnt > 0) bcnt <= bcnt - 1;
         if (s_clear != pv[3]) begin
            sq.delete();
            bcnt <= 3;
         end
         if (s_push != pv[2]) begin
            sq.push_back(s_din);
            bcnt <= 3;
         end
         if (s_sort != pv[1]) begin
            sq.rsort();
            bcnt <= 6;
         end
         if (s_pop != pv[0]) begin
            if (sq.size() > 0) s_dout <= sq.pop_front();
            else s_dout <= 16'hdead;
            bcnt <= 3;
         end
      end
   end

   // Monitors sampled on the falling edge
   logic [3:0] pn = 4'h0;
   int clr_t = 0, push_t = 0, sort_t = 0, pop_t = 0;
   int err_n = 0, done_n = 0, busy_n = 0;
   int cyc = 0, sort_cyc = 0, err_cyc = 0;
   logic [1:0] err_last = 2'd0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pn <= {s_clear, s_push, s_sort, s_pop};
      if (s_clear != pn[3]) clr_t <= clr_t + 1;
      if (s_push != pn[2]) push_t <= push_t + 1;
      if (s_sort != pn[1]) begin
         sort_t   <= sort_t + 1;
         sort_cyc <= cyc;
      end
      if (s_pop != pn[0]) pop_t <= pop_t + 1;
      if (err) begin
         err_n    <= err_n + 1;
         err_last <= err_code;
         err_cyc  <= cyc;
      end
      if (done) done_n <= done_n + 1;
      if (busy) busy_n <= busy_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      ntot++;
      assert (o === e) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic start_job(input int l);
      start = 1'b1;
      len   = 8'(l);
      tick(1);
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      int k = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && k < 200) begin
         tick(1);
         k++;
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [15:0] e,
                       input logic el, input int stall);
      int k = 0;
      int bad = 0;
      while (!out_valid && k < 200) begin
         tick(1);
         k++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(e));
      chk({tag, "_last"}, 32'(out_last), 32'(el));
      for (int i = 0; i < stall; i++) begin
         tick(1);
         if (out_data !== e || out_valid !== 1'b1) bad++;
      end
      if (stall > 0) chk({tag, "_stable"}, 32'(bad), 32'd0);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   task automatic wait_err(input string tag, input int e0,
                           input logic [1:0] code);
      int k = 0;
      while (err_n == e0 && k < 300) begin
         tick(1);
         k++;
      end
      chk({tag, "_errcnt"}, 32'(err_n), 32'(e0 + 1));
      chk({tag, "_code"}, 32'(err_last), 32'(code));
   endtask

   task automatic wait_sort(input int s0);
      int k = 0;
      while (sort_t == s0 && k < 300) begin
         tick(1);
         k++;
      end
      chk("sort_toggle_seen", 32'(sort_t), 32'(s0 + 1));
   endtask

   int e0, d0, t0, p0, s0, b0, c0;

   initial begin
      rstn = 1'b0; start = 1'b0; len = 8'd0; abort = 1'b0;
      in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
      tick(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s_lines", 32'({s_clear, s_push, s_sort, s_pop}), 32'd0);
      chk("rst_s_din", 32'(s_din), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_flags", 32'({err, err_code, done, out_last}), 32'd0);
      rstn = 1'b1;
      tick(2);

      // len=4: 3,1,4,2 comes back 4,3,2,1
      d0 = done_n; p0 = pop_t;
      start_job(4);
      chk("j1_busy", 32'(busy), 32'd1);
      send(16'd3); send(16'd1); send(16'd4); send(16'd2);
      recv("j1_w0", 16'd4, 1'b0, 0);
      recv("j1_w1", 16'd3, 1'b0, 0);
      recv("j1_w2", 16'd2, 1'b0, 0);
      recv("j1_w3", 16'd1, 1'b1, 0);
      tick(3);
      chk("j1_done_pulses", 32'(done_n), 32'(d0 + 1));
      chk("j1_pops", 32'(pop_t), 32'(p0 + 4));
      chk("j1_busy_end", 32'(busy), 32'd0);

      // len=0 and len above MAX_LEN are rejected
      e0 = err_n; b0 = busy_n;
      t0 = clr_t + push_t + sort_t + pop_t;
      start_job(0);
      tick(3);
      chk("len0_errcnt", 32'(err_n), 32'(e0 + 1));
      chk("len0_code", 32'(err_last), 32'd1);
      chk("len0_no_toggle", 32'(clr_t + push_t + sort_t + pop_t), 32'(t0));
      chk("len0_no_busy", 32'(busy_n), 32'(b0));
      e0 = err_n;
      start_job(201);
      tick(3);
      chk("len201_errcnt", 32'(err_n), 32'(e0 + 1));
      chk("len201_code", 32'(err_last), 32'd1);
      chk("len201_no_busy", 32'(busy_n), 32'(b0));

      // len=3 with a 10-cycle stall on every output word
      p0 = pop_t; d0 = done_n;
      start_job(3);
      send(16'd7); send(16'd9); send(16'd5);
      recv("j3_w0", 16'd9, 1'b0, 10);
      recv("j3_w1", 16'd7, 1'b0, 10);
      recv("j3_w2", 16'd5, 1'b1, 10);
      tick(3);
      chk("j3_pops", 32'(pop_t), 32'(p0 + 3));
      chk("j3_done", 32'(done_n), 32'(d0 + 1));

      // Sorter never returns idle after sort
      e0 = err_n; s0 = sort_t;
      start_job(1);
      send(16'h55);
      wait_sort(s0);
      hang = 1'b1;
      wait_err("tmo", e0, 2'd2);
      chk("tmo_latency", 32'(err_cyc - sort_cyc), 32'd50);
      tick(1);
      chk("tmo_idle", 32'(busy), 32'd0);
      hang = 1'b0;
      tick(5);

      // Abort during SORT_W is held until the sorter finishes
      e0 = err_n; s0 = sort_t;
      start_job(3);
      send(16'd1); send(16'd2); send(16'd3);
      wait_sort(s0);
      hang = 1'b1;
      p0 = pop_t;
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(10);
      chk("abt_held_err", 32'(err_n), 32'(e0));
      chk("abt_held_busy", 32'(busy), 32'd1);
      hang = 1'b0;
      wait_err("abt", e0, 2'd3);
      tick(2);
      chk("abt_busy", 32'(busy), 32'd0);
      chk("abt_no_pop", 32'(pop_t), 32'(p0));
      d0 = done_n;
      start_job(2);
      send(16'h10); send(16'h20);
      recv("j2_w0", 16'h20, 1'b0, 0);
      recv("j2_w1", 16'h10, 1'b1, 0);
      tick(3);
      chk("j2_done", 32'(done_n), 32'(d0 + 1));

      // start and abort together while busy
      e0 = err_n;
      start_job(2);
      send(16'h7);
      begin
         int k = 0;
         while (!in_ready && k < 200) begin
            tick(1);
            k++;
         end
      end
      c0 = clr_t;
      start = 1'b1; len = 8'd1; abort = 1'b1;
      tick(1);
      start = 1'b0; abort = 1'b0;
      tick(4);
      chk("sa_errcnt", 32'(err_n), 32'(e0 + 1));
      chk("sa_code", 32'(err_last), 32'd3);
      chk("sa_no_clear", 32'(clr_t), 32'(c0));
      chk("sa_busy", 32'(busy), 32'd0);

      // abort drops a pending output word
      e0 = err_n;
      start_job(1);
      send(16'h9);
      begin
         int k = 0;
         while (!out_valid && k < 200) begin
            tick(1);
            k++;
         end
      end
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(2);
      chk("ao_valid", 32'(out_valid), 32'd0);
      chk("ao_code", 32'(err_last), 32'd3);
      chk("ao_errcnt", 32'(err_n), 32'(e0 + 1));

      // reset mid-job gives no done or err
      start_job(2);
      send(16'h1);
      e0 = err_n; d0 = done_n;
      rstn = 1'b0;
      tick(2);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_lines", 32'({s_clear, s_push, s_sort, s_pop}), 32'd0);
      rstn = 1'b1;
      tick(3);
      chk("mr_no_err", 32'(err_n), 32'(e0));
      chk("mr_no_done", 32'(done_n), 32'(d0));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
